// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding and default baud divider.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    // 100 MHz clock / 115200 baud
    localparam int unsigned UART_CLK_DIV_DEFAULT = 868;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = UART_CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    // Free-running bit counter, held at zero while clear is asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter fed from a TX FIFO read port: start, LSB-first data,
// optional even parity (UART_TX_PARITY_EN), stop.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CLK_DIV = UART_CLK_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_re,
    output logic             tx,
    output logic             busy
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    tx_state_e        state;
    tx_state_e        state_next;
    logic             tx_next;
    logic             bit_tick;
    logic             cnt_clear;
    logic             last_bit;
    logic [WIDTH-1:0] shift;
    logic [IW-1:0]    bit_idx;
`ifdef UART_TX_PARITY_EN
    logic             parity;
`endif

    // Counter runs only while a frame is on the line; leaving FETCH starts START at zero
    assign cnt_clear = (state == IDLE) || (state == FETCH);
    assign last_bit  = (bit_idx == IW'(WIDTH - 1));

    uart_baud_cnt #(
        .CLK_DIV(CLK_DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .tick  (bit_tick)
    );

    // State register plus line flop; tx follows the state one cycle behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tx    <= 1'b1;
        end else begin
            state <= state_next;
            tx    <= tx_next;
        end
    end

    // Next-state decode: advance on bit boundaries
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (fifo_re) state_next = FETCH;
            FETCH:  state_next = START;
            START:  if (bit_tick) state_next = DATA;
            DATA: begin
                if (bit_tick && last_bit) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_tick) state_next = STOP;
`endif
            STOP:   if (bit_tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; fifo_re is gated by rst_n so it is low throughout reset
    always_comb begin
        fifo_re = 1'b0;
        busy    = 1'b1;
        tx_next = 1'b1;
        case (state)
            IDLE: begin
                busy    = 1'b0;
                fifo_re = rst_n && !fifo_empty;
            end
            FETCH:  tx_next = 1'b1;
            START:  tx_next = 1'b0;
            DATA:   tx_next = shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_next = parity;
`endif
            STOP:   tx_next = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Datapath: load the popped word in FETCH, shift out one bit per boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift   <= '0;
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else if (state == FETCH) begin
            shift   <= fifo_dout;
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            parity  <= ^fifo_dout;
`endif
        end else if ((state == DATA) && bit_tick) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + IW'(1);
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine (WIDTH=8, CLK_DIV=4).
module tb_uart_tx_engine;

    localparam int unsigned W   = 8;
    localparam int unsigned DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned P = 1;
`else
    localparam int unsigned P = 0;
`endif
    localparam int unsigned NB    = 2 + W + P;
    localparam int unsigned FRAME = NB * DIV;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         fifo_empty;
    logic [W-1:0] fifo_dout = '0;
    logic         fifo_re;
    logic         tx;
    logic         busy;

    // FIFO model: stimulus owns the write side, the clocked block owns the read side
    logic [7:0] mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    logic [7:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_re_cyc = -1000;

    uart_tx_engine #(
        .WIDTH   (W),
        .CLK_DIV (DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_re    (fifo_re),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (fifo_re) begin
            fifo_dout <= mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [7:0] w);
        mem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(w);
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (fifo_empty && !busy && tx && (exp_q.size() == 0)) begin
                done = 1'b1;
                break;
            end
        end
        check("idle_timeout", done, 1);
        repeat (4) @(negedge clk);
    endtask

    // fifo_re pulse shape/spacing and busy window length
    int   busy_run = 0;
    logic prev_re  = 1'b0;
    logic have_re  = 1'b0;
    logic cont     = 1'b0;
    initial begin : pulse_mon
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_run = 0;
                prev_re  = 1'b0;
                have_re  = 1'b0;
                cont     = 1'b0;
            end else begin
                if (fifo_re) begin
                    check("re_single_pulse", prev_re, 0);
                    if (have_re && cont)
                        check("re_spacing", cyc - last_re_cyc, FRAME + 2);
                    else if (have_re)
                        check("re_spacing_min", int'((cyc - last_re_cyc) >= int'(FRAME + 2)), 1);
                    last_re_cyc = cyc;
                    have_re = 1'b1;
                    cont    = 1'b1;
                end else if (fifo_empty) begin
                    cont = 1'b0;
                end
                if (busy) begin
                    busy_run++;
                end else if (busy_run > 0) begin
                    check("busy_len", busy_run, FRAME + 1);
                    busy_run = 0;
                end
                prev_re = fifo_re;
            end
        end
    end

    // Line monitor: decode each frame and compare with the oldest pushed word
    logic [FRAME-1:0] smp;
    logic [7:0]       want;
    logic [7:0]       got;
    logic             have;
    logic             aborted;
    int               unstable;
    initial begin : line_mon
        forever begin
            @(negedge clk);
            if (rst_n && (tx === 1'b0)) begin
                check("pop_to_start", cyc - last_re_cyc, 3);
                have = (exp_q.size() > 0);
                check("frame_expected", have, 1);
                want = have ? exp_q.pop_front() : 8'h00;
                aborted = 1'b0;
                for (int k = 0; k < int'(FRAME); k++) begin
                    if (k > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    smp[k] = tx;
                end
                if (!aborted && have) begin
                    unstable = 0;
                    for (int b = 0; b < int'(NB); b++)
                        for (int j = 1; j < int'(DIV); j++)
                            if (smp[b*DIV + j] !== smp[b*DIV]) unstable++;
                    for (int i = 0; i < int'(W); i++) got[i] = smp[(1 + i)*DIV];
                    check("bit_stable", unstable, 0);
                    check("data_byte", got, want);
`ifdef UART_TX_PARITY_EN
                    check("parity_bit", smp[(1 + W)*DIV], $countones(want) % 2);
`endif
                    check("stop_bit", smp[(NB - 1)*DIV], 1);
                end
            end
        end
    end

    logic found;
    int   n;
    initial begin : stim
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // reset with a non-empty FIFO
        push(8'hA5);
        repeat (6) begin
            @(negedge clk);
            check("rst_tx", tx, 1);
            check("rst_busy", busy, 0);
            check("rst_fifo_re", fifo_re, 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        wait_idle();

        // parity vectors (plain frames without the macro)
        @(posedge clk); #1 push(8'h07);
        wait_idle();
        @(posedge clk); #1 push(8'h03);
        wait_idle();

        // back-to-back words
        @(posedge clk); #1;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_idle();

        // reset during DATA bit 3, second word must follow intact
        @(posedge clk); #1;
        push(8'h5A);
        push(8'hC3);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_re) begin
                found = 1'b1;
                break;
            end
        end
        check("re_seen", found, 1);
        repeat (20) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_fifo_re", fifo_re, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("re_after_rst", fifo_re, 1);
        wait_idle();

        // empty FIFO
        repeat (100) begin
            @(negedge clk);
            check("empty_fifo_re", fifo_re, 0);
            check("empty_tx", tx, 1);
            check("empty_busy", busy, 0);
        end

        // random bursts with random gaps
        for (int r = 0; r < 8; r++) begin
            @(posedge clk); #1;
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) push(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 60)) @(posedge clk);
        end
        wait_idle();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Serial transmitter stage that sits directly downstream of the TX FIFO. It pops one word at a time from the FIFO read port and serializes it onto the UART line: start bit, data LSB first, optional parity bit, stop bit. The line rate is set by an internal baud divider. A new frame starts whenever the FIFO is non-empty and the engine is idle.

## Interface
- `WIDTH`, 8 — data bits per frame; must match the FIFO word width.
- `CLK_DIV`, 868 — clock cycles per bit (100 MHz / 115200); must be ≥ 2.

- `clk`  in  1  — single clock; all logic on rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `fifo_empty`  in  1  — FIFO empty flag.
- `fifo_dout`  in  WIDTH  — FIFO read data; registered in the FIFO, valid the cycle after a read.
- `fifo_re`  out  1  — FIFO read enable; single-cycle pulse per popped word.
- `tx`  out  1  — serial line; idle high.
- `busy`  out  1  — high whenever state ≠ IDLE.

## Operation
- **States:** IDLE, FETCH, START, DATA, PARITY, STOP.
- **IDLE**
  - `fifo_re = (state == IDLE) && !fifo_empty`, decoded combinationally from registered state.
  - When `fifo_re` is high, the next state is FETCH.
- **FETCH**
  - Lasts exactly one cycle; `fifo_empty` is ignored here.
  - At the exiting edge, `fifo_dout` loads the shift register and the state becomes START.
- **Baud counter**
  - Width is `$clog2(CLK_DIV)`; it clears to 0 on entry to START.
  - It counts 0..CLK_DIV-1. A bit boundary occurs at `count == CLK_DIV-1`, where the counter wraps to 0.
- **Per-state line value**
  - START: `tx = 0` for one bit time, then DATA.
  - DATA: `tx` = shift register bit 0. The register shifts right and a bit index increments at each boundary. After bit WIDTH-1, go to PARITY if enabled, else STOP.
  - PARITY: `tx` = parity bit for one bit time, then STOP.
  - STOP: `tx = 1` for one bit time, then IDLE.
- **`tx` register:** `tx` is a flop, updated on the same edge as the state register. No combinational path from inputs to `tx`.
- **Back-to-back frames:** at least 2 idle-high cycles (IDLE + FETCH) separate consecutive frames.
- **Reset (including mid-frame)**
  - Asynchronously forces: state IDLE, `tx = 1`, `busy = 0`, counter 0, shift register 0, bit index 0.
  - `fifo_re` therefore drops to 0 immediately.
  - A word already popped is lost. No partial frame resumes.

## Timing
- **Pop to start:** with `fifo_re` sampled high at edge N, state is FETCH after N and `tx` falls at edge N+2.
- **Frame length:** (2 + WIDTH + P) × CLK_DIV cycles, where P = 1 with parity and 0 without.
- **Pulse spacing:** consecutive `fifo_re` pulses with a continuously non-empty FIFO are frame length + 2 cycles apart.
- **`busy` window:** high from the edge entering FETCH to the edge returning to IDLE.
- **Reset values:** `tx = 1`, `busy = 0`, `fifo_re = 0`.

## Configuration
- **Macro:** `UART_TX_PARITY_EN`.
- **Defined:** the PARITY state exists and transmits even parity, i.e. XOR of the WIDTH data bits, so the total ones count including parity is even. Frame = WIDTH + 3 bits.
- **Undefined:** the PARITY state and its logic are not compiled; DATA goes directly to STOP. Frame = WIDTH + 2 bits.

## Structure
- **Package `uart_pkg`:** state enum `tx_state_e` and the default `CLK_DIV` constant, shared with the future RX stage.
- **Sub-module `uart_baud_cnt`:** parameterized counter with a synchronous clear input and a `tick` output at `count == CLK_DIV-1`.

## Test plan
All scenarios use WIDTH=8 and CLK_DIV=4.
1. **Reset:** assert `rst_n = 0` with `fifo_empty = 0`. Required: `tx = 1`, `busy = 0`, `fifo_re = 0` throughout reset.
2. **Single byte, no parity:** push 0xA5.
   - Exactly one `fifo_re` pulse; `tx` falls 2 cycles later.
   - Data bits 1,0,1,0,0,1,0,1, 4 cycles each; stop high 4 cycles.
   - `busy` high for 41 cycles (FETCH + 40).
3. **Parity, `UART_TX_PARITY_EN` defined:**
   - 0x07 gives parity bit 1; 0x03 gives parity bit 0.
   - Each frame is 44 cycles; stop bit follows parity.
4. **Back-to-back:** FIFO holds 0x11, 0x22, 0x33. Required: 3 `fifo_re` pulses spaced exactly 42 cycles apart; decoded line bytes match in order.
5. **Mid-frame reset:** pulse `rst_n` low during DATA bit 3.
   - `tx` returns to 1 asynchronously and `busy = 0`.
   - After release with the FIFO non-empty, a new `fifo_re` fires on the first IDLE cycle and a full frame follows.
6. **Empty FIFO:** hold `fifo_empty = 1` for 100 cycles. Required: no `fifo_re`, `tx = 1`, `busy = 0`.
